branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised successor to the EXE-stage branch resolver. Combines the existing B-type condition evaluation with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. Predicts in IF, resolves in EXE, and raises `clear` plus a redirect PC only on a misprediction, so correctly predicted branches cost no flush. Also keeps resolved-branch and mispredict statistics counters.

## Interface
- `DATAWIDTH`, 32: PC and ALU result width.
- `BTB_ENTRIES`, 64: number of entries; must be a power of two, at least 2.
- `CNT_INIT`, 2'b01: counter value written on reset (weakly not-taken).
- `CNT_ALLOC`, 2'b10: counter value written when a new entry is allocated (weakly taken).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-high (asserted = 1). The codebase's reset name is kept even though the polarity is high.
- `if_pc`  in  DATAWIDTH  fetch PC.
- `if_pred_taken`  out  1  predict taken for `if_pc`.
- `if_pred_target`  out  DATAWIDTH  predicted target; 0 when `if_pred_taken`=0.
- `ex_valid`  in  1  the EXE-stage instruction is valid.
- `ex_b_type`  in  1  the EXE-stage instruction is a B-type branch.
- `ex_pc`  in  DATAWIDTH  PC of the EXE-stage instruction.
- `ex_func3`  in  3  branch func3 field.
- `ex_alu_res`  in  DATAWIDTH  ALU result; bit 0 is the SLT/SLTU outcome.
- `ex_alu_zero`  in  1  ALU zero flag.
- `ex_target`  in  DATAWIDTH  computed branch target.
- `ex_pred_taken`  in  1  prediction carried down the pipeline from IF.
- `ex_pred_target`  in  DATAWIDTH  predicted target carried down the pipeline from IF.
- `clear`  out  1  flush IF/ID and redirect fetch.
- `redirect_pc`  out  DATAWIDTH  correct next PC, valid when `clear`=1.
- `branch_cnt`  out  32  number of resolved branches.
- `mispredict_cnt`  out  32  number of mispredictions.

## Operation
- **Index and tag.**
  - IDX_W = log2(BTB_ENTRIES).
  - Index = pc[IDX_W+1:2].
  - Tag = pc[DATAWIDTH-1:IDX_W+2].
  - Each entry holds {valid, tag, target, cnt[1:0]}.
- **Lookup (combinational, IF).**
  - Hit = valid & (tag matches).
  - `if_pred_taken` = hit & cnt[1].
  - `if_pred_target` = entry target when predicting taken, else 0.
- **Condition evaluation (EXE)**, by func3 bits [2] and [0]:
  - 0x0 (BEQ/undefined 010): taken = `ex_alu_zero`.
  - 0x1 (BNE/011): taken = ~`ex_alu_zero`.
  - 1x0 (BLT/BLTU): taken = `ex_alu_res[0]`.
  - 1x1 (BGE/BGEU): taken = ~`ex_alu_res[0]`.
- **Resolve.** Resolve = `ex_valid` & `ex_b_type`.
- **Mispredict.** mis = resolve & ((taken != `ex_pred_taken`) | (taken & `ex_pred_taken` & (`ex_target` != `ex_pred_target`))).
- **Flush outputs.**
  - `clear` = mis.
  - `redirect_pc` = taken ? `ex_target` : `ex_pc`+4. Arithmetic is modulo 2^DATAWIDTH, so 0xFFFFFFFC+4 = 0.
  - When `clear`=0, `redirect_pc` = `ex_pc`+4 (don't-care, but deterministic).
- **Update on resolve (at the clock edge).**
  - Hit on `ex_pc`: cnt saturating increment if taken, else saturating decrement (11 stays 11, 00 stays 00). If taken, target <= `ex_target`.
  - Miss, taken: allocate. Write valid=1, tag, target, cnt=`CNT_ALLOC`. This unconditionally overwrites the indexed entry.
  - Miss, not taken: no write.
- **Statistics.**
  - `branch_cnt` += 1 per resolve.
  - `mispredict_cnt` += 1 per mis.
  - Both saturate at 0xFFFFFFFF.
- **Non-branch cycles.** When `ex_valid`=0 or `ex_b_type`=0: no update, `clear`=0.

## Timing
- Lookup and resolve are combinational: zero-cycle latency from `if_pc` or EXE inputs to outputs.
- BTB writes and counter updates take effect on the rising edge after resolve.
- Read-during-write to the same index in the same cycle: IF sees the pre-update entry.
- Reset, asynchronous while `rst_n`=1:
  - All valid bits cleared; cnt = `CNT_INIT`; targets and tags = 0.
  - `branch_cnt` = `mispredict_cnt` = 0.
  - `clear`, `if_pred_taken` and `if_pred_target` are forced to 0.
- Reset asserted mid-operation aborts any pending update; the first edge after deassertion may update.
- At most one resolve per cycle; there is no back-pressure.

## Structure
- **Shared package** holds:
  - func3 codes: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
  - The BTB entry struct type.
- **Sub-module `branch_cond_eval`**: combinational taken decision from func3, zero and alu_res[0]. It replaces the standalone EXE resolver.
- The BTB storage is a register array, so reset clears it asynchronously and no SRAM macro is used.

## Test plan
- **Cold miss, taken.** Reset, then resolve BEQ at pc=0x100, `ex_alu_zero`=1, target 0x80, pred 0 -> `clear`=1, `redirect_pc`=0x80. Next cycle `if_pc`=0x100 -> `if_pred_taken`=1, target 0x80.
- **Counter saturation.** Taken 3 more times at 0x100 -> cnt=11, `clear`=0 each time. Then 1 not-taken -> `clear`=1, `redirect_pc`=0x104, cnt=10, still predicts taken.
- **Target mismatch.** BNE taken, pred taken with pred target 0x200 vs `ex_target` 0x240 -> `clear`=1, `redirect_pc`=0x240. Entry target becomes 0x240.
- **Aliasing.** With BTB_ENTRIES=64, pc 0x100 and 0x200 (same index, different tag): lookup of 0x200 -> `if_pred_taken`=0. A taken resolve at 0x200 evicts 0x100.
- **BGE/BLTU decisions and statistics.** BGE with alu_res[0]=1 -> not taken. BLTU with alu_res[0]=1 -> taken. `ex_valid`=0 with `ex_b_type`=1 -> no count, no update. Counters match the number of resolves and mispredicts.
- **Asynchronous reset mid-run.** Assert `rst_n`=1 between edges -> `clear`=0 and all predictions 0 immediately; counters read 0.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit_pkg
// Description : Shared definitions for the branch prediction unit: B-type
//               func3 codes, 2-bit saturating counter encodings, the
//               width-independent part of a BTB entry and the counter
//               update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_predict_unit_pkg;

    // B-type func3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit saturating counter encodings; bit 1 is the taken prediction
    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Width-independent part of a BTB entry; tag and target widths depend
    // on the instantiating module's parameters and are added there.
    typedef struct packed {
        logic       valid;
        logic [1:0] cnt;
    } btb_state_t;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt,
                                              input logic       taken);
        if (taken)
            return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
        else
            return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_eval
// Description : Combinational taken decision for B-type branches.
//   i_func3   branch func3 field
//   i_zero    ALU zero flag (equality compare)
//   i_lt      ALU result bit 0 (SLT/SLTU outcome)
//   o_taken   branch condition holds
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import branch_predict_unit_pkg::*;
(
    input  logic [2:0] i_func3,
    input  logic       i_zero,
    input  logic       i_lt,
    output logic       o_taken
);

    // Only func3 bits [2] and [0] matter; the undefined 010/011 codes
    // therefore behave like BEQ/BNE.
    always_comb begin
        o_taken = 1'b0;
        case (i_func3)
            F3_BEQ,  3'b010:  o_taken =  i_zero;
            F3_BNE,  3'b011:  o_taken = ~i_zero;
            F3_BLT,  F3_BLTU: o_taken =  i_lt;
            F3_BGE,  F3_BGEU: o_taken = ~i_lt;
            default:          o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Direct-mapped BTB with 2-bit counters. Predicts in IF,
//               resolves B-type branches in EXE and raises clear with a
//               redirect PC only on a misprediction. Keeps resolved-branch
//               and mispredict counters.
//   clk, rst_n                  clock; asynchronous active-high reset
//   if_pc -> if_pred_taken/if_pred_target       IF lookup (combinational)
//   ex_*  -> clear/redirect_pc                  EXE resolve (combinational)
//   branch_cnt, mispredict_cnt                  saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         DATAWIDTH   = 32,
    parameter int         BTB_ENTRIES = 64,
    parameter logic [1:0] CNT_INIT    = CNT_WNT,
    parameter logic [1:0] CNT_ALLOC   = CNT_WT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] if_pc,
    output logic                 if_pred_taken,
    output logic [DATAWIDTH-1:0] if_pred_target,
    input  logic                 ex_valid,
    input  logic                 ex_b_type,
    input  logic [DATAWIDTH-1:0] ex_pc,
    input  logic [2:0]           ex_func3,
    input  logic [DATAWIDTH-1:0] ex_alu_res,
    input  logic                 ex_alu_zero,
    input  logic [DATAWIDTH-1:0] ex_target,
    input  logic                 ex_pred_taken,
    input  logic [DATAWIDTH-1:0] ex_pred_target,
    output logic                 clear,
    output logic [DATAWIDTH-1:0] redirect_pc,
    output logic [31:0]          branch_cnt,
    output logic [31:0]          mispredict_cnt
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = DATAWIDTH - IDX_W - 2;

    typedef struct packed {
        btb_state_t           st;
        logic [TAG_W-1:0]     tag;
        logic [DATAWIDTH-1:0] target;
    } entry_t;

    entry_t r_btb [BTB_ENTRIES];
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    // ---------------- IF lookup ----------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic             w_if_taken;

    assign w_if_idx   = if_pc[IDX_W+1:2];
    assign w_if_tag   = if_pc[DATAWIDTH-1:IDX_W+2];
    assign w_if_hit   = r_btb[w_if_idx].st.valid && (r_btb[w_if_idx].tag == w_if_tag);
    // Gated by reset so the outputs drop the instant reset asserts.
    assign w_if_taken = w_if_hit && r_btb[w_if_idx].st.cnt[1] && !rst_n;

    assign if_pred_taken  = w_if_taken;
    assign if_pred_target = w_if_taken ? r_btb[w_if_idx].target : '0;

    // ---------------- EXE resolve ----------------
    logic                 w_taken;
    logic                 w_resolve;
    logic                 w_mis;
    logic [IDX_W-1:0]     w_ex_idx;
    logic [TAG_W-1:0]     w_ex_tag;
    logic                 w_ex_hit;
    logic [DATAWIDTH-1:0] w_ex_pc_plus4;

    branch_cond_eval u_cond_eval (
        .i_func3 (ex_func3),
        .i_zero  (ex_alu_zero),
        .i_lt    (ex_alu_res[0]),
        .o_taken (w_taken)
    );

    assign w_resolve     = ex_valid && ex_b_type;
    assign w_mis         = w_resolve &&
                           ((w_taken != ex_pred_taken) ||
                            (w_taken && ex_pred_taken && (ex_target != ex_pred_target)));
    assign w_ex_idx      = ex_pc[IDX_W+1:2];
    assign w_ex_tag      = ex_pc[DATAWIDTH-1:IDX_W+2];
    assign w_ex_hit      = r_btb[w_ex_idx].st.valid && (r_btb[w_ex_idx].tag == w_ex_tag);
    assign w_ex_pc_plus4 = ex_pc + DATAWIDTH'(4);

    assign clear       = w_mis && !rst_n;
    // Fall-through PC whenever no redirect is taken, so the value is stable.
    assign redirect_pc = (clear && w_taken) ? ex_target : w_ex_pc_plus4;

    // ---------------- State update ----------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb[i].st.valid <= 1'b0;
                r_btb[i].st.cnt   <= CNT_INIT;
                r_btb[i].tag      <= '0;
                r_btb[i].target   <= '0;
            end
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_resolve) begin
                if (w_ex_hit) begin
                    r_btb[w_ex_idx].st.cnt <= cnt_update(r_btb[w_ex_idx].st.cnt, w_taken);
                    if (w_taken)
                        r_btb[w_ex_idx].target <= ex_target;
                end else if (w_taken) begin
                    // Allocation evicts whatever lives at this index.
                    r_btb[w_ex_idx].st.valid <= 1'b1;
                    r_btb[w_ex_idx].st.cnt   <= CNT_ALLOC;
                    r_btb[w_ex_idx].tag      <= w_ex_tag;
                    r_btb[w_ex_idx].target   <= ex_target;
                end
                if (r_branch_cnt != 32'hFFFF_FFFF)
                    r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mis && (r_mispredict_cnt != 32'hFFFF_FFFF))
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

    // Word-offset bits of the fetch PC and upper ALU result bits carry no
    // information for prediction or condition evaluation.
    logic w_unused_bits;
    assign w_unused_bits = ^{if_pc[1:0], ex_alu_res[DATAWIDTH-1:1]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Self-checking bench for branch_predict_unit: directed vector
//               table, randomized traffic against a behavioural model, and
//               an asynchronous reset in the middle of a cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam int DW  = 32;
    localparam int ENT = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] if_pc;
    logic          if_pred_taken;
    logic [DW-1:0] if_pred_target;
    logic          ex_valid, ex_b_type;
    logic [DW-1:0] ex_pc;
    logic [2:0]    ex_func3;
    logic [DW-1:0] ex_alu_res;
    logic          ex_alu_zero;
    logic [DW-1:0] ex_target;
    logic          ex_pred_taken;
    logic [DW-1:0] ex_pred_target;
    logic          clear;
    logic [DW-1:0] redirect_pc;
    logic [31:0]   branch_cnt, mispredict_cnt;

    branch_predict_unit #(.DATAWIDTH(DW), .BTB_ENTRIES(ENT)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_b_type(ex_b_type), .ex_pc(ex_pc),
        .ex_func3(ex_func3), .ex_alu_res(ex_alu_res), .ex_alu_zero(ex_alu_zero),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .clear(clear), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- Behavioural model ----------------
    // Plain arrays indexed by word address modulo table size.
    bit          m_valid [ENT];
    int unsigned m_tag   [ENT];
    int unsigned m_tgt   [ENT];
    int          m_cnt   [ENT];
    int unsigned m_br, m_mis;

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % ENT;
    endfunction
    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / (4 * ENT);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
        end
        m_br = 0; m_mis = 0;
    endtask

    function automatic bit m_hit(input int unsigned pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input int unsigned pc);
        return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
    endfunction

    function automatic bit m_cond(input int f3, input bit zero, input bit lt);
        case (f3)
            0, 2:    return zero;
            1, 3:    return !zero;
            4, 6:    return lt;
            default: return !lt;
        endcase
    endfunction

    function automatic bit m_misp(input bit tk);
        if (!(ex_valid && ex_b_type)) return 0;
        if (tk != ex_pred_taken) return 1;
        return tk && (ex_target != ex_pred_target);
    endfunction

    task automatic m_check(input string tag);
        bit tk, mis;
        int unsigned exp_rpc;
        tk  = m_cond(int'(ex_func3), ex_alu_zero, ex_alu_res[0]);
        mis = m_misp(tk);
        exp_rpc = (mis && tk) ? ex_target : ex_pc + 4;
        chk({tag, " pred_taken"}, 64'(if_pred_taken), 64'(m_pred(if_pc)));
        chk({tag, " pred_target"}, 64'(if_pred_target),
            64'(m_pred(if_pc) ? m_tgt[idx_of(if_pc)] : 0));
        chk({tag, " clear"}, 64'(clear), 64'(mis));
        chk({tag, " redirect"}, 64'(redirect_pc), 64'(exp_rpc));
        chk({tag, " branch_cnt"}, 64'(branch_cnt), 64'(m_br));
        chk({tag, " mispredict_cnt"}, 64'(mispredict_cnt), 64'(m_mis));
    endtask

    task automatic m_update();
        bit tk;
        int unsigned i;
        if (!(ex_valid && ex_b_type)) return;
        tk = m_cond(int'(ex_func3), ex_alu_zero, ex_alu_res[0]);
        i  = idx_of(ex_pc);
        if (m_misp(tk) && m_mis != 32'hFFFF_FFFF) m_mis++;
        if (m_br != 32'hFFFF_FFFF) m_br++;
        if (m_hit(ex_pc)) begin
            m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                          : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            if (tk) m_tgt[i] = ex_target;
        end else if (tk) begin
            m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target; m_cnt[i] = 2;
        end
    endtask

    // ---------------- Directed vector table ----------------
    typedef struct {
        logic [31:0] ifpc;
        logic        vld, bt;
        logic [2:0]  f3;
        logic        zero, lt;
        logic [31:0] pc, tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_clr;
        logic [31:0] e_rpc;
        logic        e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs [13];

    task automatic drive(input logic [31:0] ifpc, input logic vld, input logic bt,
                         input logic [2:0] f3, input logic zero, input logic lt,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
        if_pc = ifpc; ex_valid = vld; ex_b_type = bt; ex_func3 = f3;
        ex_alu_zero = zero; ex_alu_res = {$urandom_range(0, 255), 23'd0, lt};
        ex_pc = pc; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    initial begin
        // if_pc  vld bt f3  z  lt  ex_pc        tgt    ptk ptgt   | clr rpc  tk tgt
        vecs[0]  = '{32'h100, 1,1,3'b000,1,0, 32'h100, 32'h080, 0, 32'h0,   1, 32'h080, 0, 32'h0};
        vecs[1]  = '{32'h100, 1,1,3'b000,1,0, 32'h100, 32'h080, 1, 32'h080, 0, 32'h104, 1, 32'h080};
        vecs[2]  = '{32'h100, 1,1,3'b000,1,0, 32'h100, 32'h080, 1, 32'h080, 0, 32'h104, 1, 32'h080};
        vecs[3]  = '{32'h100, 1,1,3'b000,1,0, 32'h100, 32'h080, 1, 32'h080, 0, 32'h104, 1, 32'h080};
        vecs[4]  = '{32'h100, 1,1,3'b000,0,0, 32'h100, 32'h080, 1, 32'h080, 1, 32'h104, 1, 32'h080};
        vecs[5]  = '{32'h100, 0,0,3'b000,0,0, 32'h100, 32'h000, 0, 32'h0,   0, 32'h104, 1, 32'h080};
        vecs[6]  = '{32'h100, 1,1,3'b001,0,0, 32'h100, 32'h240, 1, 32'h200, 1, 32'h240, 1, 32'h080};
        vecs[7]  = '{32'h100, 1,0,3'b000,1,0, 32'h100, 32'h999, 0, 32'h0,   0, 32'h104, 1, 32'h240};
        vecs[8]  = '{32'h200, 1,1,3'b000,1,0, 32'h200, 32'h300, 0, 32'h0,   1, 32'h300, 0, 32'h0};
        vecs[9]  = '{32'h100, 0,1,3'b000,1,0, 32'h200, 32'h700, 0, 32'h0,   0, 32'h204, 0, 32'h0};
        vecs[10] = '{32'h200, 1,1,3'b101,0,1, 32'h404, 32'h600, 0, 32'h0,   0, 32'h408, 1, 32'h300};
        vecs[11] = '{32'h404, 1,1,3'b110,0,1, 32'h404, 32'h500, 0, 32'h0,   1, 32'h500, 0, 32'h0};
        vecs[12] = '{32'h404, 1,1,3'b100,0,0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 1, 32'h0, 1, 32'h500};

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("reset branch_cnt", 64'(branch_cnt), 64'd0);
        chk("reset mispredict_cnt", 64'(mispredict_cnt), 64'd0);
        chk("reset clear", 64'(clear), 64'd0);
        chk("reset pred", 64'(if_pred_taken), 64'd0);

        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            drive(vecs[v].ifpc, vecs[v].vld, vecs[v].bt, vecs[v].f3, vecs[v].zero,
                  vecs[v].lt, vecs[v].pc, vecs[v].tgt, vecs[v].ptk, vecs[v].ptgt);
            #2;
            chk($sformatf("vec%0d clear", v), 64'(clear), 64'(vecs[v].e_clr));
            chk($sformatf("vec%0d redirect", v), 64'(redirect_pc), 64'(vecs[v].e_rpc));
            chk($sformatf("vec%0d pred_taken", v), 64'(if_pred_taken), 64'(vecs[v].e_tk));
            chk($sformatf("vec%0d pred_target", v), 64'(if_pred_target), 64'(vecs[v].e_tgt));
            @(posedge clk);
            m_update();
        end
        @(negedge clk);
        drive(32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("table branch_cnt", 64'(branch_cnt), 64'd10);
        chk("table mispredict_cnt", 64'(mispredict_cnt), 64'd6);
        chk("evicted 0x100 now 0x200 pred", 64'(if_pred_target), 64'h300);

        // ---------------- Randomized traffic ----------------
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rpc, rifpc;
            logic        rptk;
            @(negedge clk);
            rpc   = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 2);
            rifpc = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            rptk  = m_pred(rpc);
            if ($urandom_range(0, 7) == 0) rptk = !rptk;
            drive(rifpc, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  rpc, ($urandom_range(0, 3) << 4) + 32'h1000, rptk,
                  ($urandom_range(0, 1) != 0) ? m_tgt[idx_of(rpc)] : 32'h1010);
            #2;
            m_check($sformatf("rnd%0d", n));
            @(posedge clk);
            m_update();
        end

        // ---------------- Asynchronous reset mid-cycle ----------------
        @(negedge clk);
        drive(32'h100, 1, 1, 3'b000, 1, 0, 32'h100, 32'h0C0, 0, 32'h0);
        @(posedge clk);
        m_update();
        @(negedge clk);
        drive(32'h100, 1, 1, 3'b000, 0, 0, 32'h100, 32'h0C0, 1, 32'h0C0);
        #2;
        m_check("pre-reset");
        chk("pre-reset pred_taken set", 64'(if_pred_taken), 64'd1);
        rst_n = 1'b1;
        #1;
        chk("async reset clear", 64'(clear), 64'd0);
        chk("async reset pred_taken", 64'(if_pred_taken), 64'd0);
        chk("async reset pred_target", 64'(if_pred_target), 64'd0);
        chk("async reset branch_cnt", 64'(branch_cnt), 64'd0);
        chk("async reset mispredict_cnt", 64'(mispredict_cnt), 64'd0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive(32'h100, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0);
        #2;
        m_check("post-reset");
        chk("post-reset pred_taken", 64'(if_pred_taken), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
